mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning the number of clock edges from read acceptance to read data valid; legal range 1..7.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the word count of internal storage (256 x 32-bit words).
REQ-003 The block SHALL have port clock, input, 1 bit, meaning the system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning asynchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 1 bit, meaning the initiator requests a memory access this cycle.
REQ-006 The block SHALL have port we, input, 1 bit, meaning the access type: 1 = write, 0 = read; sampled with req.
REQ-007 The block SHALL have port addr, input, 32 bits, meaning the byte address of the access.
REQ-008 The block SHALL have port wdata, input, 32 bits, meaning the write data; sampled with req.
REQ-009 The block SHALL have port rdata, output, 32 bits, meaning the read data; valid while ready=1 after a read.
REQ-010 The block SHALL have port ready, output, 1 bit, meaning a one-cycle completion pulse for the accepted access.
REQ-011 The block SHALL have port busy, output, 1 bit, meaning an access is in progress and req is ignored.
REQ-012 The block SHALL have port err, output, 1 bit, meaning the completing access was misaligned; valid only with ready.
REQ-013 The block SHALL have port state, output, 2 bits, meaning the current FSM state for debug visibility.

Function
REQ-014 The FSM SHALL have states IDLE=2'd0, WAIT=2'd1 and RESP=2'd2; encoding 2'd3 is unreachable and SHALL go to IDLE.
REQ-015 busy SHALL equal (state != IDLE); ready SHALL equal (state == RESP).
REQ-016 Acceptance SHALL occur only at a rising edge where state=IDLE and req=1; addr, we and wdata are latched at that edge, and req at any other time is ignored.
REQ-017 The word index SHALL be addr[DEPTH_LOG2+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*2^DEPTH_LOG2 bytes.
REQ-018 A misaligned access (addr[1:0] != 0) SHALL set err=1 for its RESP cycle; a misaligned write SHALL NOT modify storage, and a misaligned read SHALL return rdata=0.
REQ-019 Write: storage SHALL update at the acceptance edge; the FSM SHALL go IDLE->RESP, giving ready=1 in the cycle after acceptance (latency 1).
REQ-020 Read with LATENCY=1: the FSM SHALL go IDLE->RESP, with rdata loaded at the acceptance edge.
REQ-021 Read with LATENCY>1: the FSM SHALL go IDLE->WAIT with the 3-bit counter loaded to LATENCY-2.
REQ-022 In WAIT, the counter SHALL decrement each edge; when it reaches 0, the FSM SHALL go to RESP and rdata SHALL load from the latched index, so ready=1 in the cycle after the LATENCY-th edge following acceptance.
REQ-023 RESP SHALL last exactly one cycle, then go to IDLE; back-to-back accesses SHALL therefore be separated by at least one IDLE cycle.
REQ-024 rdata SHALL hold its last loaded value until the next read completes; writes SHALL NOT change rdata.
REQ-025 err SHALL clear on leaving RESP.

Reset
REQ-026 While reset=1: state=IDLE, ready=0, busy=0, err=0, rdata=0, and the counter and latched address/data SHALL be 0.
REQ-027 Reset asserted mid-access (WAIT or RESP) SHALL abort the access immediately; no ready pulse SHALL follow.
REQ-028 Storage contents SHALL NOT be cleared by reset; a write accepted at the same edge reset asserts SHALL be discarded.
REQ-029 After reset deasserts, the first rising edge with req=1 SHALL be accepted.

Verification
REQ-030 Write 0xDEADBEEF to 0x10, then read 0x10 (LATENCY=2) -> ready one cycle after write acceptance, err=0; read ready exactly 2 edges after acceptance; rdata=0xDEADBEEF; busy=1 between acceptance and ready.
REQ-031 Read at 0x3 -> ready with err=1, rdata=0; preceding write of 0x12345678 to 0x2 -> err=1, and a following read of 0x0 returns the old word unchanged.
REQ-032 Write 0xA5A5A5A5 to 0x404 (DEPTH_LOG2=8), read 0x004 -> rdata=0xA5A5A5A5 (wrap).
REQ-033 Hold req=1 continuously with alternating addresses -> exactly one acceptance per IDLE cycle; req during WAIT/RESP produces no extra ready pulses.
REQ-034 Start a read, assert reset in WAIT -> state=0, ready never pulses, rdata=0; a post-reset read of a previously written word still returns that word.
REQ-035 Re-run REQ-030 with LATENCY=1 and LATENCY=7 -> ready exactly 1 and 7 edges after read acceptance respectively.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a simple req/ready handshake.
// Writes complete in one cycle. Reads complete LATENCY edges after acceptance,
// counting the acceptance edge itself. Misaligned accesses complete with err
// set; they never write storage, and a misaligned read returns zero.
module mem_responder #(
   parameter int LATENCY    = 2,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        err,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } stateT;

   localparam int         WORDS     = 2 ** DEPTH_LOG2;
   // On the first WAIT edge the counter already holds LATENCY-2. It ends
   // WAIT on the edge where it is zero, so a read spends LATENCY-1 edges in
   // WAIT.
   localparam logic [2:0] WAIT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

   stateT                  stateReg, stateNext;
   logic [2:0]             countReg, countNext;
   logic                   errReg, errNext;
   logic [31:0]            rdataReg, rdataNext;
   logic [DEPTH_LOG2-1:0]  idxReg;
   logic                   misReg;

   logic [31:0]            mem [0:WORDS-1];

   logic                   accept;
   logic                   misaligned;
   logic [DEPTH_LOG2-1:0]  wordIdx;
   logic                   unusedAddrBits;

   assign accept         = (stateReg == IDLE) && req;
   assign misaligned     = (addr[1:0] != 2'b00);
   assign wordIdx        = addr[DEPTH_LOG2+1:2];
   // Address bits above the storage size are ignored, so accesses wrap.
   assign unusedAddrBits = ^addr[31:DEPTH_LOG2+2];

   // Storage write at the acceptance edge. There is no reset here, so
   // contents survive reset. A write presented while reset is high is dropped.
   always_ff @(posedge clock) begin
      if (!reset && accept && we && !misaligned) begin
         mem[wordIdx] <= wdata;
      end
   end

   // Latch the word index and alignment of the accepted access for the
   // delayed read.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idxReg <= '0;
         misReg <= 1'b0;
      end else if (accept) begin
         idxReg <= wordIdx;
         misReg <= misaligned;
      end
   end

   // State, counter, err and read-data registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stateReg <= IDLE;
         countReg <= 3'd0;
         errReg   <= 1'b0;
         rdataReg <= 32'd0;
      end else begin
         stateReg <= stateNext;
         countReg <= countNext;
         errReg   <= errNext;
         rdataReg <= rdataNext;
      end
   end

   // Next-state logic. err is set only on entry to RESP and cleared on exit.
   // rdata loads only when a read enters RESP.
   always_comb begin
      stateNext = stateReg;
      countNext = countReg;
      errNext   = errReg;
      rdataNext = rdataReg;
      case (stateReg)
         IDLE: begin
            if (req) begin
               if (we) begin
                  stateNext = RESP;
                  errNext   = misaligned;
               end else if (LATENCY == 1) begin
                  stateNext = RESP;
                  errNext   = misaligned;
                  rdataNext = misaligned ? 32'd0 : mem[wordIdx];
               end else begin
                  stateNext = WAIT;
                  countNext = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            if (countReg == 3'd0) begin
               stateNext = RESP;
               errNext   = misReg;
               rdataNext = misReg ? 32'd0 : mem[idxReg];
            end else begin
               countNext = countReg - 3'd1;
            end
         end
         RESP: begin
            stateNext = IDLE;
            errNext   = 1'b0;
         end
         default: begin
            stateNext = IDLE;
            errNext   = 1'b0;
            countNext = 3'd0;
         end
      endcase
   end

   assign rdata = rdataReg;
   assign ready = (stateReg == RESP);
   assign busy  = (stateReg != IDLE);
   assign err   = errReg;
   assign state = stateReg;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders with LATENCY 2, 1 and 7 share one
// stimulus. The LATENCY=2 responder is checked through a scoreboard queue.
// All three are checked for completion latency, rdata and err on every
// transaction.
module tb_mem_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req   = 1'b0;
   logic        we    = 1'b0;
   logic [31:0] addr  = 32'd0;
   logic [31:0] wdata = 32'd0;

   logic [31:0] rdata2, rdata1, rdata7;
   logic        ready2, ready1, ready7;
   logic        busy2, busy1, busy7;
   logic        err2, err1, err7;
   logic [1:0]  state2, state1, state7;

   mem_responder #(.LATENCY(2), .DEPTH_LOG2(8)) dut2 (
      .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata2), .ready(ready2), .busy(busy2), .err(err2), .state(state2));
   mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut1 (
      .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata1), .ready(ready1), .busy(busy1), .err(err1), .state(state1));
   mem_responder #(.LATENCY(7), .DEPTH_LOG2(8)) dut7 (
      .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata7), .ready(ready7), .busy(busy7), .err(err7), .state(state7));

   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expRdata;
      logic        expErr;
   } vecT;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } expT;

   expT         sbQ[$];
   expT         sbItem;
   int          checks  = 0;
   int          passes  = 0;
   int          rdyCnt2 = 0;
   int          rdyCnt1 = 0;
   int          rdyCnt7 = 0;
   logic [31:0] lastRead = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   // Count ready pulses. Score every LATENCY=2 completion against the queue.
   always @(negedge clock) begin
      if (ready1) rdyCnt1++;
      if (ready7) rdyCnt7++;
      if (ready2) begin
         rdyCnt2++;
         if (sbQ.size() == 0) begin
            check("sb_unexpected_ready_queue_size", 32'(sbQ.size()), 32'd1);
         end else begin
            sbItem = sbQ.pop_front();
            $display("sb: rdata=%h err=%0d", rdata2, err2);
            check("sb_rdata", rdata2, sbItem.rdata);
            check("sb_err", 32'(err2), 32'(sbItem.err));
         end
      end
   end

   // Drive one access, then measure each responder's completion edge.
   // Edges are counted with the acceptance edge as edge 1.
   task automatic doAccess(input vecT v);
      int          lat2, lat1, lat7, exp2, exp1, exp7;
      logic [31:0] rd1, rd7, expRd;
      logic        er1, er7, busyOk;
      lat2 = 0; lat1 = 0; lat7 = 0; busyOk = 1'b1;
      rd1 = 32'd0; rd7 = 32'd0; er1 = 1'b0; er7 = 1'b0;
      expRd = v.we ? lastRead : v.expRdata;
      @(negedge clock);
      req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
      sbQ.push_back('{rdata: expRd, err: v.expErr});
      $display("txn: %s addr=%h wdata=%h exp_rdata=%h exp_err=%0d",
               v.we ? "WR" : "RD", v.addr, v.wdata, expRd, v.expErr);
      @(posedge clock);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         if (k == 1) req = 1'b0;
         if (lat2 == 0) begin
            if (ready2) lat2 = k;
            else if (!busy2) busyOk = 1'b0;
         end
         if (ready1 && lat1 == 0) begin lat1 = k; rd1 = rdata1; er1 = err1; end
         if (ready7 && lat7 == 0) begin lat7 = k; rd7 = rdata7; er7 = err7; end
         if (lat2 != 0 && lat1 != 0 && lat7 != 0) break;
      end
      exp2 = v.we ? 1 : 2;
      exp1 = 1;
      exp7 = v.we ? 1 : 7;
      check("latency_L2", 32'(lat2), 32'(exp2));
      check("latency_L1", 32'(lat1), 32'(exp1));
      check("latency_L7", 32'(lat7), 32'(exp7));
      if (!v.we) check("busy_before_ready_L2", 32'(busyOk), 32'd1);
      check("rdata_L1", rd1, expRd);
      check("err_L1", 32'(er1), 32'(v.expErr));
      check("rdata_L7", rd7, expRd);
      check("err_L7", 32'(er7), 32'(v.expErr));
      if (!v.we) lastRead = v.expRdata;
   endtask

   // Stop a hung run with a FAIL line rather than letting it run forever.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecT vecs[14];
      vecT rv;
      int  c1, c2, c7;
      vecs[0]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0,         1'b0};
      vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
      vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_0002, 32'h1234_5678, 32'h0,         1'b1};
      vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
      vecs[5]  = '{1'b0, 32'h0000_0003, 32'h0,         32'h0,         1'b1};
      vecs[6]  = '{1'b1, 32'h0000_0404, 32'hA5A5_A5A5, 32'h0,         1'b0};
      vecs[7]  = '{1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_A5A5, 1'b0};
      vecs[8]  = '{1'b1, 32'h0000_0006, 32'h0BAD_F00D, 32'h0,         1'b1};
      vecs[9]  = '{1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_A5A5, 1'b0};
      vecs[10] = '{1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'h0,         1'b0};
      vecs[11] = '{1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 1'b0};
      vecs[12] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[13] = '{1'b0, 32'h0000_0001, 32'h0,         32'h0,         1'b1};

      // While reset is held, every output must read zero.
      repeat (2) @(negedge clock);
      check("reset_state", 32'(state2), 32'd0);
      check("reset_ready", 32'(ready2), 32'd0);
      check("reset_busy",  32'(busy2),  32'd0);
      check("reset_err",   32'(err2),   32'd0);
      check("reset_rdata", rdata2,      32'd0);
      reset = 1'b0;

      for (int i = 0; i < 14; i++) doAccess(vecs[i]);

      // Hold req high for edges 0..11 while alternating addresses. Accepts
      // land at edges 0,3,6,9 for LATENCY 2, at every even edge for
      // LATENCY 1, and at edges 0,8 for LATENCY 7.
      @(negedge clock);
      c1 = rdyCnt1; c2 = rdyCnt2; c7 = rdyCnt7;
      sbQ.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
      sbQ.push_back('{rdata: 32'h1111_1111, err: 1'b0});
      sbQ.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
      sbQ.push_back('{rdata: 32'h1111_1111, err: 1'b0});
      $display("txn: RD held req for 12 cycles, alternating addr 0x10/0x0");
      for (int t = 0; t < 12; t++) begin
         req = 1'b1; we = 1'b0; addr = (t % 2 == 0) ? 32'h10 : 32'h0;
         @(negedge clock);
      end
      req = 1'b0;
      repeat (12) @(negedge clock);
      check("held_req_pulses_L2", 32'(rdyCnt2 - c2), 32'd4);
      check("held_req_pulses_L1", 32'(rdyCnt1 - c1), 32'd6);
      check("held_req_pulses_L7", 32'(rdyCnt7 - c7), 32'd2);
      check("held_req_queue_empty", 32'(sbQ.size()), 32'd0);

      // Load rdata, start another read, then assert reset while it is in
      // WAIT. The read must abort and rdata must return to zero.
      rv = '{1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0};
      doAccess(rv);
      @(negedge clock);
      req = 1'b1; we = 1'b0; addr = 32'h0000_0004;
      $display("txn: RD addr=00000004 aborted by reset in WAIT");
      @(posedge clock);
      @(negedge clock);
      req = 1'b0;
      c2 = rdyCnt2; c7 = rdyCnt7;
      reset = 1'b1;
      #1;
      check("abort_state_L2", 32'(state2), 32'd0);
      check("abort_busy_L2",  32'(busy2),  32'd0);
      check("abort_ready_L2", 32'(ready2), 32'd0);
      check("abort_rdata_L2", rdata2,      32'd0);
      check("abort_state_L7", 32'(state7), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (10) @(negedge clock);
      check("abort_no_ready_L2", 32'(rdyCnt2 - c2), 32'd0);
      check("abort_no_ready_L7", 32'(rdyCnt7 - c7), 32'd0);
      lastRead = 32'd0;

      // A write presented on the same edge that reset asserts is dropped.
      @(negedge clock);
      req = 1'b1; we = 1'b1; addr = 32'h0000_0010; wdata = 32'h0000_0000;
      reset = 1'b1;
      $display("txn: WR addr=00000010 wdata=00000000 dropped under reset");
      @(negedge clock);
      req = 1'b0; we = 1'b0;
      reset = 1'b0;

      // Storage survives reset: the first access afterwards reads the old word.
      rv = '{1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0};
      doAccess(rv);
      repeat (3) @(negedge clock);
      check("final_queue_empty", 32'(sbQ.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
